// File: rtl/load_store_unit_if.sv
// Data-memory port of the load/store unit: one read and one write channel,
// each a valid/ready handshake with address and data.
interface load_store_unit_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              mem_read_valid;
    logic [ADDR_W-1:0] mem_read_address;
    logic              mem_read_ready;
    logic [DATA_W-1:0] mem_read_data;
    logic              mem_write_valid;
    logic [ADDR_W-1:0] mem_write_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write_ready;

    modport master (
        output mem_read_valid, mem_read_address,
        input  mem_read_ready, mem_read_data,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_write_ready
    );

    modport slave (
        input  mem_read_valid, mem_read_address,
        output mem_read_ready, mem_read_data,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_write_ready
    );
endinterface

// File: rtl/load_store_unit.sv
// Per-thread load/store unit: runs one LDR/STR against the data-memory controller.
// Define LSU_TIMEOUT_EN to add a WAITING watchdog that reports through lsu_error.
module load_store_unit #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [2:0]        core_state,
    input  logic              mem_read_enable,
    input  logic              mem_write_enable,
    input  logic [7:0]        rs_data,
    input  logic [7:0]        rt_data,
    load_store_unit_if.master mem,
    output logic [1:0]        lsu_state,
    output logic [7:0]        lsu_out,
    output logic              lsu_error
);
    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        REQUESTING = 2'b01,
        WAITING    = 2'b10,
        DONE       = 2'b11
    } state_t;

    localparam logic [2:0] CORE_ISSUE  = 3'b010;
    localparam logic [2:0] CORE_UPDATE = 3'b110;

    if (ADDR_W < 8 || DATA_W < 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_params
        $error("load_store_unit: unsupported parameter values");
    end

    state_t state, state_n;
    logic   is_load;
    logic   launch, complete, sel_ready;

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt;
    logic       timed_out;
`endif

    // Only the channel this instruction uses can complete it.
    assign sel_ready = is_load ? mem.mem_read_ready : mem.mem_write_ready;
    assign lsu_state = state;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n  = state;
        launch   = 1'b0;
        complete = 1'b0;
`ifdef LSU_TIMEOUT_EN
        timed_out = 1'b0;
`endif
        if (enable) begin
            unique case (state)
                IDLE: begin
                    if (core_state == CORE_ISSUE && (mem_read_enable || mem_write_enable)) begin
                        launch  = 1'b1;
                        state_n = REQUESTING;
                    end
                end
                REQUESTING: state_n = WAITING;
                WAITING: begin
                    if (sel_ready) begin
                        complete = 1'b1;
                        state_n  = DONE;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (wait_cnt == TIMEOUT_LAST) begin
                        timed_out = 1'b1;
                        state_n   = DONE;
                    end
`endif
                end
                DONE: begin
                    if (core_state == CORE_UPDATE) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            is_load               <= 1'b0;
            mem.mem_read_valid    <= 1'b0;
            mem.mem_read_address  <= '0;
            mem.mem_write_valid   <= 1'b0;
            mem.mem_write_address <= '0;
            mem.mem_write_data    <= '0;
            lsu_out               <= '0;
        end else if (enable) begin
            // LDR has priority; a simultaneous store is dropped entirely.
            if (launch) begin
                is_load <= mem_read_enable;
                if (mem_read_enable) begin
                    mem.mem_read_address <= ADDR_W'(rs_data);
                end else begin
                    mem.mem_write_address <= ADDR_W'(rs_data);
                    mem.mem_write_data    <= DATA_W'(rt_data);
                end
            end
            if (state == REQUESTING) begin
                mem.mem_read_valid  <= is_load;
                mem.mem_write_valid <= !is_load;
            end
            if (complete) begin
                mem.mem_read_valid  <= 1'b0;
                mem.mem_write_valid <= 1'b0;
                if (is_load) lsu_out <= mem.mem_read_data[7:0];
            end
`ifdef LSU_TIMEOUT_EN
            if (timed_out) begin
                mem.mem_read_valid  <= 1'b0;
                mem.mem_write_valid <= 1'b0;
                if (is_load) lsu_out <= 8'hFF;
            end
`endif
        end
    end

`ifdef LSU_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt  <= '0;
            lsu_error <= 1'b0;
        end else if (enable) begin
            if (state == REQUESTING)   wait_cnt <= '0;
            else if (state == WAITING) wait_cnt <= wait_cnt + 8'd1;
            if (launch)         lsu_error <= 1'b0;
            else if (timed_out) lsu_error <= 1'b1;
        end
    end
`else
    assign lsu_error = 1'b0;
`endif
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a transaction-level model.
module tb_load_store_unit;
    localparam int         TO     = 4;
    localparam logic [2:0] ISSUE  = 3'b010;
    localparam logic [2:0] UPDATE = 3'b110;
`ifdef LSU_TIMEOUT_EN
    localparam int MAX_DELAY = TO - 1;
`else
    localparam int MAX_DELAY = 6;
`endif

    logic       clk = 1'b0;
    logic       reset, enable;
    logic [2:0] core_state;
    logic       mem_read_enable, mem_write_enable;
    logic [7:0] rs_data, rt_data;
    logic [1:0] lsu_state;
    logic [7:0] lsu_out;
    logic       lsu_error;

    load_store_unit_if #(.ADDR_W(8), .DATA_W(8)) mem_if ();

    load_store_unit #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYCLES(TO)) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .core_state       (core_state),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .rs_data          (rs_data),
        .rt_data          (rt_data),
        .mem              (mem_if),
        .lsu_state        (lsu_state),
        .lsu_out          (lsu_out),
        .lsu_error        (lsu_error)
    );

    always #5 clk = ~clk;

    // {state, rvalid, wvalid, raddr, waddr, wdata, lsu_out, lsu_error}
    logic [36:0] obs;
    assign obs = {lsu_state, mem_if.mem_read_valid, mem_if.mem_write_valid,
                  mem_if.mem_read_address, mem_if.mem_write_address,
                  mem_if.mem_write_data, lsu_out, lsu_error};

    int passed = 0;
    int total  = 0;

    // Model of what the unit should be holding after each transaction.
    logic [7:0] m_out, m_raddr, m_waddr, m_wdata;
    logic       m_err;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_out = 8'h00; m_raddr = 8'h00; m_waddr = 8'h00; m_wdata = 8'h00; m_err = 1'b0;
    endtask

    task automatic quiet_inputs();
        core_state = 3'b000;
        mem_read_enable = 1'b0;
        mem_write_enable = 1'b0;
        mem_if.mem_read_ready = 1'b0;
        mem_if.mem_write_ready = 1'b0;
        mem_if.mem_read_data = 8'($urandom);
    endtask

    task automatic launch(input logic ld, input logic st, input logic [7:0] rs, input logic [7:0] rt);
        core_state = ISSUE;
        mem_read_enable = ld;
        mem_write_enable = st;
        rs_data = rs;
        rt_data = rt;
        step();
        core_state = 3'b011;
        mem_read_enable = 1'($urandom);
        mem_write_enable = 1'($urandom);
        rs_data = 8'($urandom);
        rt_data = 8'($urandom);
        if (ld) m_raddr = rs;
        else if (st) begin
            m_waddr = rs;
            m_wdata = rt;
        end
        m_err = 1'b0;
    endtask

    task automatic run_txn(input logic ld, input logic st, input logic [7:0] rs, input logic [7:0] rt,
                           input int delay, input logic [7:0] rdata, input string tag);
        logic [36:0] exp;
        int vcnt = 0;
        launch(ld, st, rs, rt);
        exp = {2'b01, 1'b0, 1'b0, m_raddr, m_waddr, m_wdata, m_out, m_err};
        total++;
        if (obs !== exp) $display("FAIL %s requesting: got %h want %h", tag, obs, exp);
        else passed++;
        step();
        for (int k = 0; k <= delay; k++) begin
            exp = {2'b10, ld, !ld, m_raddr, m_waddr, m_wdata, m_out, m_err};
            total++;
            if (obs !== exp) $display("FAIL %s waiting k=%0d: got %h want %h", tag, k, obs, exp);
            else passed++;
            if (mem_if.mem_read_valid || mem_if.mem_write_valid) vcnt++;
            mem_if.mem_read_data = (k == delay) ? rdata : 8'($urandom);
            mem_if.mem_read_ready  = ld ? (k == delay) : 1'($urandom);
            mem_if.mem_write_ready = ld ? 1'($urandom) : (k == delay);
            step();
        end
        quiet_inputs();
        if (ld) m_out = rdata;
        exp = {2'b11, 1'b0, 1'b0, m_raddr, m_waddr, m_wdata, m_out, m_err};
        total++;
        if (obs !== exp) $display("FAIL %s done: got %h want %h", tag, obs, exp);
        else passed++;
        total++;
        if (vcnt !== delay + 1) $display("FAIL %s valid_cycles: got %0d want %0d", tag, vcnt, delay + 1);
        else passed++;
        for (int d = 0; d < int'($urandom_range(0, 3)); d++) begin
            core_state = 3'($urandom_range(0, 6));
            if (core_state == UPDATE) core_state = 3'b111;
            step();
            total++;
            if (lsu_state !== 2'b11) $display("FAIL %s done_hold: got %b want 11", tag, lsu_state);
            else passed++;
        end
        core_state = UPDATE;
        step();
        total++;
        if (lsu_state !== 2'b00) $display("FAIL %s update_idle: got %b want 00", tag, lsu_state);
        else passed++;
        core_state = 3'b000;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        enable = 1'b1;
        rs_data = 8'h00;
        rt_data = 8'h00;
        quiet_inputs();
        step();
        step();
        reset = 1'b1;
        model_clear();
        total++;
        if (obs !== 37'h0) $display("FAIL reset_state: got %h want %h", obs, 37'h0);
        else passed++;
    endtask

    task automatic test_ldr();
        run_txn(1'b1, 1'b0, 8'h2A, 8'h00, 1, 8'h5C, "ldr_2a");
        total++;
        if (lsu_out !== 8'h5C) $display("FAIL ldr_out_persist: got %h want 5c", lsu_out);
        else passed++;
    endtask

    task automatic test_str();
        run_txn(1'b0, 1'b1, 8'h10, 8'hC3, 0, 8'h00, "str_10");
        total++;
        if (lsu_out !== 8'h5C) $display("FAIL str_out_unchanged: got %h want 5c", lsu_out);
        else passed++;
    endtask

    task automatic test_both_enables();
        run_txn(1'b1, 1'b1, 8'h77, 8'hEE, 2, 8'h31, "both_en");
    endtask

    task automatic test_no_launch();
        // ISSUE without an op, ops outside ISSUE, and enable low must all stay IDLE.
        core_state = ISSUE;
        mem_if.mem_read_ready = 1'b1;
        mem_if.mem_write_ready = 1'b1;
        step();
        total++;
        if (obs !== {2'b00, 2'b00, m_raddr, m_waddr, m_wdata, m_out, m_err})
            $display("FAIL idle_no_op: got %h", obs);
        else passed++;
        core_state = UPDATE;
        mem_read_enable = 1'b1;
        step();
        total++;
        if (lsu_state !== 2'b00) $display("FAIL idle_not_issue: got %b want 00", lsu_state);
        else passed++;
        enable = 1'b0;
        core_state = ISSUE;
        rs_data = 8'h99;
        step();
        total++;
        if (obs !== {2'b00, 2'b00, m_raddr, m_waddr, m_wdata, m_out, m_err})
            $display("FAIL idle_disabled: got %h", obs);
        else passed++;
        enable = 1'b1;
        quiet_inputs();
    endtask

    task automatic test_freeze();
        logic [36:0] exp;
        launch(1'b1, 1'b0, 8'h4D, 8'h00);
        step();
        enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_if.mem_read_ready = (k % 2 == 0);
            mem_if.mem_read_data = 8'($urandom);
            core_state = UPDATE;
            step();
            exp = {2'b10, 1'b1, 1'b0, m_raddr, m_waddr, m_wdata, m_out, m_err};
            total++;
            if (obs !== exp) $display("FAIL freeze k=%0d: got %h want %h", k, obs, exp);
            else passed++;
        end
        enable = 1'b1;
        mem_if.mem_read_ready = 1'b0;
        core_state = 3'b000;
        step();
        total++;
        if (lsu_state !== 2'b10) $display("FAIL freeze_resume_wait: got %b want 10", lsu_state);
        else passed++;
        mem_if.mem_read_ready = 1'b1;
        mem_if.mem_read_data = 8'hA6;
        step();
        quiet_inputs();
        m_out = 8'hA6;
        exp = {2'b11, 1'b0, 1'b0, m_raddr, m_waddr, m_wdata, m_out, m_err};
        total++;
        if (obs !== exp) $display("FAIL freeze_done: got %h want %h", obs, exp);
        else passed++;
        core_state = UPDATE;
        step();
        core_state = 3'b000;
    endtask

    task automatic test_reset_mid();
        launch(1'b1, 1'b0, 8'hB2, 8'h00);
        step();
        total++;
        if (mem_if.mem_read_valid !== 1'b1) $display("FAIL rst_mid_pre: got %b want 1", mem_if.mem_read_valid);
        else passed++;
        reset = 1'b0;
        step();
        reset = 1'b1;
        model_clear();
        total++;
        if (obs !== 37'h0) $display("FAIL rst_mid: got %h want %h", obs, 37'h0);
        else passed++;
        step();
        total++;
        if (lsu_state !== 2'b00) $display("FAIL rst_mid_stay_idle: got %b want 00", lsu_state);
        else passed++;
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        logic [36:0] exp;
        launch(1'b1, 1'b0, 8'h3E, 8'h00);
        step();
        for (int k = 0; k < TO; k++) begin
            exp = {2'b10, 1'b1, 1'b0, m_raddr, m_waddr, m_wdata, m_out, m_err};
            total++;
            if (obs !== exp) $display("FAIL timeout_wait k=%0d: got %h want %h", k, obs, exp);
            else passed++;
            mem_if.mem_write_ready = 1'b1;
            step();
        end
        quiet_inputs();
        m_out = 8'hFF;
        m_err = 1'b1;
        exp = {2'b11, 1'b0, 1'b0, m_raddr, m_waddr, m_wdata, m_out, m_err};
        total++;
        if (obs !== exp) $display("FAIL timeout_done: got %h want %h", obs, exp);
        else passed++;
        core_state = UPDATE;
        step();
        core_state = 3'b000;
        run_txn(1'b0, 1'b1, 8'h05, 8'h06, 1, 8'h00, "after_timeout");
    endtask
`else
    task automatic test_long_wait();
        run_txn(1'b1, 1'b0, 8'hD0, 8'h00, 300, 8'h1B, "long_wait");
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            int op = int'($urandom_range(0, 2));
            run_txn(op != 1, op != 0, 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, MAX_DELAY)), 8'($urandom), "rand");
        end
    endtask

    initial begin
        test_reset();
        test_ldr();
        test_str();
        test_both_enables();
        test_no_launch();
        test_freeze();
        test_reset_mid();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
